// File: rtl/ftdi_pkg.sv
// Shared FTDI bridge definitions: receiver FSM encoding and 8N1 frame constants.
// The transmitter reuses the frame constants so both directions agree on the frame.
package ftdi_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_STOP      = ST_STOP,
    S_WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_e;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DATA_BITS          = 8;
  localparam int STOP_BITS          = 1;

endpackage

// File: rtl/ftdi_receiver_if.sv
// Consumer-side handshake of the FTDI receiver: held valid/ack byte path,
// clear-to-send, status and sticky error flags.
interface ftdi_receiver_if;

  logic [ftdi_pkg::DATA_BITS-1:0] data;
  logic                           data_valid;
  logic                           ack;
  logic                           busy;
  logic                           cts;
  logic                           framing_error;
  logic                           overrun;
  logic                           clear_errors;

  modport master (
    output data, data_valid, busy, cts, framing_error, overrun,
    input  ack, clear_errors
  );

  modport slave (
    input  data, data_valid, busy, cts, framing_error, overrun,
    output ack, clear_errors
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-clk pulse every FREQUENCY/(BAUD_RATE*OVERSAMPLE)
// clocks. clear holds the phase at zero so the first tick lands a full period later.
module baud_tick_gen #(
  parameter int FREQUENCY  = 50_000_000,
  parameter int BAUD_RATE  = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV = FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int W   = $clog2(DIV) + 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/ftdi_receiver.sv
// 8N1 UART receiver for the host->FPGA FTDI line. Mid-bit sampling on an
// oversample tick, held valid/ack output register, sticky framing/overrun flags.
module ftdi_receiver
  import ftdi_pkg::*;
#(
  parameter int FREQUENCY  = 50_000_000,
  parameter int BAUD_RATE  = 2,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            FTDI_TX,
  ftdi_receiver_if.master bus
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 sync1, rx_s;
  rx_state_e            state, state_next;
  logic                 tick, tick_clear;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, fe_q, ov_q;
  logic                 cnt_clear, cnt_inc, bit_clear, shift_en, capture, set_fe, set_ov;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= FTDI_TX;
      rx_s  <= sync1;
    end
  end

  assign tick_clear = (state == S_IDLE);

  baud_tick_gen #(
    .FREQUENCY  (FREQUENCY),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tick_clear),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    bit_clear  = 1'b0;
    shift_en   = 1'b0;
    capture    = 1'b0;
    set_fe     = 1'b0;
    bus.busy   = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        cnt_clear = 1'b1;
        if (!rx_s) state_next = S_START;
      end
      S_START: if (tick) begin
        if (sample_cnt == HALF_LAST) begin
          cnt_clear  = 1'b1;
          bit_clear  = 1'b1;
          state_next = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DATA: if (tick) begin
        if (sample_cnt == FULL_LAST) begin
          cnt_clear = 1'b1;
          shift_en  = 1'b1;
          if (bit_idx == LAST_BIT) state_next = S_STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_STOP: if (tick) begin
        if (sample_cnt == FULL_LAST) begin
          cnt_clear = 1'b1;
          if (rx_s) begin
            capture    = 1'b1;
            state_next = S_IDLE;
          end else begin
            set_fe     = 1'b1;
            state_next = S_WAIT_IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT_IDLE: if (rx_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift      <= '0;
    end else begin
      if (cnt_clear)    sample_cnt <= '0;
      else if (cnt_inc) sample_cnt <= sample_cnt + SW'(1);
      if (bit_clear)     bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + BW'(1);
      if (shift_en) shift <= {rx_s, shift[DATA_BITS-1:1]};
    end
  end

  // A capture coinciding with ack hands over the new byte instead of overrunning.
  assign set_ov = capture && valid_q && !bus.ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      if (capture && (!valid_q || bus.ack)) begin
        data_q  <= shift;
        valid_q <= 1'b1;
      end else if (bus.ack) begin
        valid_q <= 1'b0;
      end
      fe_q <= (fe_q && !bus.clear_errors) || set_fe;
      ov_q <= (ov_q && !bus.clear_errors) || set_ov;
    end
  end

  assign bus.data          = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.cts           = !valid_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun       = ov_q;

endmodule

// File: tb/tb_ftdi_receiver.sv
// Directed bench for ftdi_receiver at 64 clk/bit: expected bytes go into a queue,
// a negedge monitor pops one on every byte presentation; flags are checked inline.
module tb_ftdi_receiver;

  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ftdi_tx = 1'b1;

  ftdi_receiver_if bus ();

  ftdi_receiver #(
    .FREQUENCY  (6_400_000),
    .BAUD_RATE  (100_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .FTDI_TX (ftdi_tx),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte presentation: data_valid rising, or data replaced while data_valid stays high.
  always @(negedge clk) begin
    if (reset_n && bus.data_valid && (!prev_valid || bus.data != prev_data)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'd0, bus.data}, 32'hFFFF_FFFF);
      end else begin
        check("rx_byte", {24'd0, bus.data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = bus.data_valid;
    prev_data  = bus.data;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_clks);
    ftdi_tx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      ftdi_tx = b[i];
      wait_clks(BIT_CLKS);
    end
    ftdi_tx = stop_bit;
    wait_clks(stop_clks);
    ftdi_tx = 1'b1;
  endtask

  task automatic wait_valid(input int max_clks, output int lat);
    lat = 0;
    while (!bus.data_valid && lat < max_clks) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.data_valid) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    wait_clks(1);
    bus.ack = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_errors = 1'b1;
    wait_clks(1);
    bus.clear_errors = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},  {24'd0, bus.data}, 32'h00);
    check({tag, "_valid"}, {31'd0, bus.data_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    check({tag, "_fe"},    {31'd0, bus.framing_error}, 32'd0);
    check({tag, "_ov"},    {31'd0, bus.overrun}, 32'd0);
    check({tag, "_cts"},   {31'd0, bus.cts}, 32'd1);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int lat;
    int busy_cnt;
    bus.ack          = 1'b0;
    bus.clear_errors = 1'b0;

    // Reset values.
    wait_clks(4);
    check_reset_values("reset");
    reset_n = 1'b1;
    wait_clks(10);

    // Frame 0x4A: latency, handshake, cts.
    exp_q.push_back(8'h4A);
    fork
      send_frame(8'h4A, 1'b1, BIT_CLKS);
      wait_valid(700, lat);
    join
    check("latency_near_608", {31'd0, (lat >= 600 && lat <= 620)}, 32'd1);
    check("4a_valid", {31'd0, bus.data_valid}, 32'd1);
    check("4a_cts",   {31'd0, bus.cts}, 32'd0);
    check("4a_fe",    {31'd0, bus.framing_error}, 32'd0);
    check("4a_ov",    {31'd0, bus.overrun}, 32'd0);
    wait_clks(5);
    pulse_ack();
    check("4a_ack_valid", {31'd0, bus.data_valid}, 32'd0);
    check("4a_ack_cts",   {31'd0, bus.cts}, 32'd1);
    check("4a_ack_data",  {24'd0, bus.data}, 32'h4A);
    pulse_ack();
    check("idle_ack_ignored", {31'd0, bus.data_valid}, 32'd0);
    wait_clks(10);

    // 16-clk low glitch: start bit rejected at its mid-point.
    fork
      begin
        ftdi_tx = 1'b0;
        wait_clks(16);
        ftdi_tx = 1'b1;
      end
      begin
        busy_cnt = 0;
        repeat (100) begin
          @(negedge clk);
          if (bus.busy) busy_cnt++;
        end
      end
    join
    check("glitch_busy_short", {31'd0, (busy_cnt >= 1 && busy_cnt <= 40)}, 32'd1);
    check("glitch_busy_end",   {31'd0, bus.busy}, 32'd0);
    check("glitch_valid",      {31'd0, bus.data_valid}, 32'd0);
    check("glitch_fe",         {31'd0, bus.framing_error}, 32'd0);
    check("glitch_ov",         {31'd0, bus.overrun}, 32'd0);

    // 0x33 with a low stop bit held 200 clk: one framing error, busy until line high.
    fork
      send_frame(8'h33, 1'b0, 200);
      begin
        wait_clks(9 * BIT_CLKS + 150);
        check("break_busy",  {31'd0, bus.busy}, 32'd1);
        check("break_fe",    {31'd0, bus.framing_error}, 32'd1);
        check("break_valid", {31'd0, bus.data_valid}, 32'd0);
      end
    join
    wait_clks(10);
    check("break_end_busy", {31'd0, bus.busy}, 32'd0);
    exp_q.push_back(8'h5C);
    fork
      send_frame(8'h5C, 1'b1, BIT_CLKS);
      wait_valid(700, lat);
    join
    check("5c_fe_sticky", {31'd0, bus.framing_error}, 32'd1);
    pulse_ack();
    pulse_clear();
    check("fe_cleared", {31'd0, bus.framing_error}, 32'd0);
    wait_clks(10);

    // 0x55 then 0xA3 back-to-back without ack: 0xA3 lost, overrun.
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, BIT_CLKS);
    send_frame(8'hA3, 1'b1, BIT_CLKS);
    wait_clks(10);
    check("ovr_data",  {24'd0, bus.data}, 32'h55);
    check("ovr_valid", {31'd0, bus.data_valid}, 32'd1);
    check("ovr_flag",  {31'd0, bus.overrun}, 32'd1);
    pulse_ack();
    check("ovr_ack_valid", {31'd0, bus.data_valid}, 32'd0);
    check("ovr_ack_data",  {24'd0, bus.data}, 32'h55);
    pulse_clear();
    check("ov_cleared", {31'd0, bus.overrun}, 32'd0);
    wait_clks(10);

    // 0x55 pending, ack on the exact capture cycle of 0xA3.
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, BIT_CLKS);
    exp_q.push_back(8'hA3);
    fork
      send_frame(8'hA3, 1'b1, BIT_CLKS);
      begin
        wait_clks(610);
        check("same_cycle_pre_valid", {31'd0, bus.data_valid}, 32'd1);
        pulse_ack();
      end
    join
    wait_clks(10);
    check("same_cycle_data",  {24'd0, bus.data}, 32'hA3);
    check("same_cycle_valid", {31'd0, bus.data_valid}, 32'd1);
    check("same_cycle_ov",    {31'd0, bus.overrun}, 32'd0);
    pulse_ack();
    wait_clks(10);

    // Reset during data bit 4 of 0xFF, then a clean 0x0F.
    fork
      send_frame(8'hFF, 1'b1, BIT_CLKS);
      begin
        wait_clks(5 * BIT_CLKS + 32);
        check("midframe_busy", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
      end
    join
    reset_n = 1'b1;
    wait_clks(10);
    check("post_reset_busy",  {31'd0, bus.busy}, 32'd0);
    check("post_reset_valid", {31'd0, bus.data_valid}, 32'd0);
    exp_q.push_back(8'h0F);
    fork
      send_frame(8'h0F, 1'b1, BIT_CLKS);
      wait_valid(700, lat);
    join
    check("0f_fe", {31'd0, bus.framing_error}, 32'd0);
    check("0f_ov", {31'd0, bus.overrun}, 32'd0);
    pulse_ack();
    wait_clks(5);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ftdi_receiver.md
Name: ftdi_receiver

Overview:
- UART receive path for the FTDI bridge. Deserialises 8N1 frames arriving on FTDI_TX (host → FPGA), which is the opposite direction to the existing FTDI transmitter.
- Presents each received byte to the top level with a held valid/ack handshake and reports framing and overrun errors.
- Drives a clear-to-send indication so the top level can throttle the host.

Parameters:
- FREQUENCY, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 2, line rate in bit/s. Same meaning as in the FTDI transmitter.
- OVERSAMPLE, 16, samples per bit period. Must be even and ≥ 4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- FTDI_TX  in  1  serial line from the FTDI chip. Idle high. Asynchronous to clk.
- ack  in  1  single-cycle pulse. Consumer has taken data.
- clear_errors  in  1  single-cycle pulse. Clears the sticky error flags.
- data  out  8  last received byte. Stable while data_valid = 1.
- data_valid  out  1  high from byte capture until ack.
- busy  out  1  high while a frame is in progress (any state except IDLE).
- cts  out  1  high when the holding register is empty (= !data_valid). Polarity is mapped at the top level.
- framing_error  out  1  sticky. Stop bit was sampled low.
- overrun  out  1  sticky. A byte was lost because data_valid was still high.

Behaviour:
- Reset (async assert, sync deassert in the top level):
  - data = 0, data_valid = 0, busy = 0, framing_error = 0, overrun = 0, cts = 1.
  - Synchroniser flops reset to 1.
  - FSM returns to IDLE.
  - Reset mid-frame abandons the partial byte. Nothing is captured.
- Input sync: 2-flop synchroniser on FTDI_TX. All decisions use the synchronised value rx_s.
- Oversample tick:
  - DIV = FREQUENCY/(BAUD_RATE*OVERSAMPLE), integer, must be ≥ 1.
  - The tick counter has width $clog2(DIV)+1 and pulses one clk every DIV cycles.
  - The counter is cleared in IDLE so each frame's sample phase is aligned to its start edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rx_s = 0 → START, sample counter = 0.
  - START: after OVERSAMPLE/2 ticks (start-bit mid-point), sample rx_s.
    - 0 → DATA, bit index = 0.
    - 1 → glitch. Return to IDLE, no flags.
  - DATA: every OVERSAMPLE ticks, sample rx_s into a shift register, LSB first. After bit index 7 → STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - 1 → capture byte (see Handshake) → IDLE.
    - 0 → framing_error = 1, byte discarded → WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then → IDLE. A held break therefore produces exactly one framing error.
- Latency: data_valid rises on the clk after the stop-bit mid-sample tick, i.e. about 9.5 bit periods after the start edge.
- Handshake:
  - On capture with data_valid = 0: data ← byte, data_valid ← 1.
  - ack while data_valid = 1: data_valid ← 0. data keeps its value.
  - ack while data_valid = 0: ignored.
  - Capture while data_valid = 1 and no ack: the new byte is dropped, data is unchanged, overrun ← 1.
  - Capture and ack in the same cycle: data ← new byte, data_valid stays 1, no overrun.
- Errors:
  - Flags are sticky until clear_errors or reset.
  - If clear_errors and a new error occur in the same cycle, the flag ends set.
  - Errors never affect data or data_valid.
- busy is asserted in START, DATA, STOP and WAIT_IDLE.

Decomposition:
- Shared package ftdi_pkg holds:
  - the FSM state encoding (3-bit localparams);
  - the default OVERSAMPLE value;
  - the frame constants DATA_BITS = 8 and STOP_BITS = 1.
- The FTDI transmitter reuses the frame constants.
- Natural sub-module: baud_tick_gen (params FREQUENCY, BAUD_RATE, OVERSAMPLE; ports clk, reset_n, clear, tick). It is shareable with the transmitter using OVERSAMPLE = 1.

Test Plan (FREQUENCY = 6_400_000, BAUD_RATE = 100_000, OVERSAMPLE = 16 → DIV = 4, 64 clk/bit):
- Frame 0x4A (line: 0, 0,1,0,1,0,0,1,0, 1) → data_valid rises about 608 clk after the start edge, data = 0x4A, cts = 0, no errors. Pulse ack → data_valid = 0, cts = 1, data still 0x4A.
- Low glitch of 16 clk on an idle line → never leaves START→IDLE path, data_valid = 0, busy high for ≤ 40 clk then 0, no flags.
- Frame 0x33 with stop bit 0, line held low 200 clk then high → framing_error = 1, data_valid = 0. busy stays 1 until the line goes high. A following 0x5C frame is received correctly. clear_errors → framing_error = 0.
- Frames 0x55 then 0xA3 back-to-back with no ack → data = 0x55, data_valid = 1, overrun = 1. ack → data_valid = 0, data = 0x55.
- 0x55 pending, ack pulsed on the exact cycle 0xA3 is captured → data = 0xA3, data_valid = 1, overrun = 0.
- reset_n low during data bit 4 of 0xFF → all outputs return to reset values immediately. After release, a 0x0F frame gives data = 0x0F with no flags.
